internal_pin_if_pio_in_irq: RTL and testbench



---
 rtl/internal_pin_if_pio_in_irq.sv | 108 ++++++++++
 tb/tb_internal_pin_if_pio_in_irq.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/internal_pin_if_pio_in_irq.sv
// Avalon-MM input PIO with per-bit edge capture and a maskable interrupt.
// Register 0 holds the synchronised live input, 2 is irqmask and 3 is W1C edgecapture.
module internal_pin_if_pio_in_irq #(
  parameter int WIDTH       = 32,
  parameter int SYNC_STAGES = 2,
  parameter int EDGE_TYPE   = 0,
  parameter int IRQ_TYPE    = 1
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  input  logic [WIDTH-1:0] in_port,
  output logic [31:0]      readdata,
  output logic             irq
);

  localparam int CNT_W = $clog2(SYNC_STAGES + 2);
  localparam logic [CNT_W-1:0] PRIME_MAX = CNT_W'(SYNC_STAGES + 1);

  // Bus handshake: zero-wait slave. A write is accepted on every clock edge where
  // chipselect=1 and write_n=0. Reads need no select; readdata registers the
  // addressed word every clock, so data appears one cycle after the address.

  logic [WIDTH-1:0] sync_q [SYNC_STAGES];
  logic [WIDTH-1:0] s;
  logic [WIDTH-1:0] s_d;
  logic [CNT_W-1:0] prime_cnt;
  logic             primed;
  logic [WIDTH-1:0] edge_det;
  logic [WIDTH-1:0] irqmask;
  logic [WIDTH-1:0] edgecapture;
  logic [WIDTH-1:0] clr_mask;
  logic             wr_en;
  logic [31:0]      rd_mux;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      s_d <= '0;
    end else begin
      sync_q[0] <= in_port;
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      s_d <= s;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Priming hides the first transitions out of reset while the chain fills.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) prime_cnt <= '0;
    else if (!primed) prime_cnt <= prime_cnt + 1'b1;
  end

  assign primed = (prime_cnt == PRIME_MAX);

  always_comb begin
    edge_det = '0;
    if (primed) begin
      case (EDGE_TYPE)
        0:       edge_det = s & ~s_d;
        1:       edge_det = ~s & s_d;
        default: edge_det = s ^ s_d;
      endcase
    end
  end

  assign wr_en    = chipselect & ~write_n;
  assign clr_mask = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      irqmask     <= '0;
      edgecapture <= '0;
    end else begin
      if (wr_en && address == 2'd2) irqmask <= writedata[WIDTH-1:0];
      // A new edge outranks a simultaneous clear of the same bit.
      edgecapture <= (edgecapture & ~clr_mask) | edge_det;
    end
  end

  always_comb begin
    rd_mux = '0;
    case (address)
      2'd0:    rd_mux[WIDTH-1:0] = s;
      2'd2:    rd_mux[WIDTH-1:0] = irqmask;
      2'd3:    rd_mux[WIDTH-1:0] = edgecapture;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) readdata <= '0;
    else          readdata <= rd_mux;
  end

  generate
    if (IRQ_TYPE == 0) begin : g_irq_level
      assign irq = |(s & irqmask);
    end else begin : g_irq_edge
      assign irq = |(edgecapture & irqmask);
    end
  endgenerate

endmodule

// File: tb/tb_internal_pin_if_pio_in_irq.sv
// Directed bench for internal_pin_if_pio_in_irq: edge-mode 32-bit, level-mode
// 32-bit and an 8-bit any-edge instance share clock, reset and bus signals.
module tb_internal_pin_if_pio_in_irq;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  address;
  logic        write_n;
  logic [31:0] writedata;
  logic        cs_a, cs_l, cs_w;
  logic [31:0] in_a, in_l;
  logic [7:0]  in_w;
  logic [31:0] rd_a, rd_l, rd_w;
  logic        irq_a, irq_l, irq_w;
  logic [31:0] r;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  internal_pin_if_pio_in_irq #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(1)) dut_a (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_a), .write_n(write_n),
    .writedata(writedata), .in_port(in_a), .readdata(rd_a), .irq(irq_a));

  internal_pin_if_pio_in_irq #(.WIDTH(32), .SYNC_STAGES(2), .EDGE_TYPE(0), .IRQ_TYPE(0)) dut_l (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_l), .write_n(write_n),
    .writedata(writedata), .in_port(in_l), .readdata(rd_l), .irq(irq_l));

  internal_pin_if_pio_in_irq #(.WIDTH(8), .SYNC_STAGES(2), .EDGE_TYPE(2), .IRQ_TYPE(1)) dut_w (
    .clk(clk), .reset_n(reset_n), .address(address), .chipselect(cs_w), .write_n(write_n),
    .writedata(writedata), .in_port(in_w), .readdata(rd_w), .irq(irq_w));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wr(input int which, input logic [1:0] a, input logic [31:0] d);
    address   = a;
    writedata = d;
    write_n   = 1'b0;
    cs_a      = (which == 0);
    cs_l      = (which == 1);
    cs_w      = (which == 2);
    tick(1);
    write_n = 1'b1;
    cs_a    = 1'b0;
    cs_l    = 1'b0;
    cs_w    = 1'b0;
  endtask

  task automatic rd(input int which, input logic [1:0] a, output logic [31:0] d);
    address = a;
    tick(1);
    case (which)
      0:       d = rd_a;
      1:       d = rd_l;
      default: d = rd_w;
    endcase
  endtask

  initial begin
    reset_n   = 1'b0;
    address   = 2'd0;
    write_n   = 1'b1;
    writedata = '0;
    cs_a = 1'b0; cs_l = 1'b0; cs_w = 1'b0;
    in_a = 32'hFFFF_FFFF;
    in_l = '0;
    in_w = '0;
    tick(3);
    chk("reset_irq", {31'd0, irq_a}, 32'd0);
    chk("reset_readdata", rd_a, 32'd0);

    // Inputs held high through reset must not look like rising edges.
    reset_n = 1'b1;
    tick(10);
    rd(0, 2'd3, r); chk("prime_edgecapture", r, 32'd0);
    chk("prime_irq", {31'd0, irq_a}, 32'd0);
    rd(0, 2'd0, r); chk("prime_data", r, 32'hFFFF_FFFF);

    in_a = '0;
    tick(4);
    rd(0, 2'd3, r); chk("fall_ignored", r, 32'd0);
    rd(0, 2'd0, r); chk("data_zero", r, 32'd0);

    wr(0, 2'd2, 32'h1);
    rd(0, 2'd2, r); chk("irqmask_rd", r, 32'h1);

    in_a[0] = 1'b1;
    tick(1); chk("rise_irq_e0", {31'd0, irq_a}, 32'd0);
    tick(1); chk("rise_irq_e1", {31'd0, irq_a}, 32'd0);
    tick(1); chk("rise_irq_e2", {31'd0, irq_a}, 32'd1);
    rd(0, 2'd3, r); chk("rise_edgecapture", r, 32'h1);
    wr(0, 2'd3, 32'h1);
    chk("w1c_irq", {31'd0, irq_a}, 32'd0);

    wr(0, 2'd2, 32'h8);
    in_a = in_a | 32'h28;
    tick(3);
    chk("mask_irq", {31'd0, irq_a}, 32'd1);
    rd(0, 2'd3, r); chk("mask_edgecapture", r, 32'h28);
    wr(0, 2'd3, 32'h8);
    chk("mask_clr_irq", {31'd0, irq_a}, 32'd0);
    rd(0, 2'd3, r); chk("mask_clr_edgecapture", r, 32'h20);

    // Rising edge on bit 2 lands on the same clock edge as the clear of bit 2.
    in_a = in_a | 32'h4;
    tick(2);
    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, r); chk("set_wins", r, 32'h24);
    wr(0, 2'd3, 32'h4);
    rd(0, 2'd3, r); chk("plain_clear", r, 32'h20);

    rd(0, 2'd1, r); chk("addr1_zero", r, 32'd0);
    wr(0, 2'd0, 32'h0);
    wr(0, 2'd1, 32'hFFFF_FFFF);
    rd(0, 2'd0, r); chk("addr0_write_ignored", r, 32'h2D);
    rd(0, 2'd2, r); chk("addr1_write_ignored", r, 32'h8);

    // Level-sensitive instance.
    wr(1, 2'd2, 32'h2);
    in_l = 32'h2;
    tick(1); chk("lvl_rise_e0", {31'd0, irq_l}, 32'd0);
    tick(1); chk("lvl_rise_e1", {31'd0, irq_l}, 32'd1);
    in_l = 32'h0;
    tick(1); chk("lvl_fall_e0", {31'd0, irq_l}, 32'd1);
    tick(1); chk("lvl_fall_e1", {31'd0, irq_l}, 32'd0);
    rd(1, 2'd3, r); chk("lvl_edgecapture", r, 32'h2);
    chk("lvl_irq_ignores_capture", {31'd0, irq_l}, 32'd0);

    // 8-bit any-edge instance.
    wr(2, 2'd2, 32'hFFFF_FFFF);
    rd(2, 2'd2, r); chk("w8_irqmask", r, 32'h0000_00FF);
    in_w = 8'h81;
    tick(3);
    chk("w8_irq", {31'd0, irq_w}, 32'd1);
    rd(2, 2'd3, r); chk("w8_rise_capture", r, 32'h81);
    rd(2, 2'd0, r); chk("w8_data", r, 32'h81);
    wr(2, 2'd3, 32'hFFFF_FFFF);
    chk("w8_clr_irq", {31'd0, irq_w}, 32'd0);
    in_w = 8'h01;
    tick(3);
    rd(2, 2'd3, r); chk("w8_fall_capture", r, 32'h80);

    // Reset in the middle of an active interrupt.
    wr(0, 2'd2, 32'h20);
    chk("midop_irq_before", {31'd0, irq_a}, 32'd1);
    address = 2'd0;
    tick(1);
    chk("midop_data_before", rd_a, 32'h2D);
    #2;
    reset_n = 1'b0;
    #1;
    chk("midop_irq_reset", {31'd0, irq_a}, 32'd0);
    chk("midop_readdata_reset", rd_a, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(10);
    rd(0, 2'd3, r); chk("midop_edgecapture", r, 32'd0);
    rd(0, 2'd2, r); chk("midop_irqmask", r, 32'd0);
    chk("midop_irq_after", {31'd0, irq_a}, 32'd0);
    rd(0, 2'd0, r); chk("midop_data_after", r, 32'h2D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
